// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the fetch sequencer: state encoding, offset type,
// parameter defaults and the branch offset legality helper.
package fetch_seq_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } seq_state_e;

  localparam int unsigned FLUSH_CYCLES_DEF = 6;
  localparam int unsigned MIN_OFFSET_DEF   = 7;

  // Fetch subtracts its own latency from the offset; shorter offsets would underflow.
  function automatic logic offset_legal(input addr_t off, input addr_t min_off);
    return (off >= min_off);
  endfunction

endpackage

// File: rtl/fetch_seq_sat_counter.sv
// 16-bit saturating event counter with increment enable; used for the optional
// statistics outputs of fetch_sequencer.
module fetch_seq_sat_counter
  import fetch_seq_pkg::*;
(
  input  logic  clock_i,
  input  logic  reset_i,
  input  logic  inc_i,
  output addr_t count_o
);

  addr_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: timed wrong-path flush, single redirect pulse and stall hold.
// Optional statistics counters are enabled with `define FETCH_SEQ_STATS_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned MIN_OFFSET   = MIN_OFFSET_DEF
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        branchValid_i,
  input  logic [15:0] branchOffset_i,
  input  logic        branchDirection_i,
  input  logic        stall_i,
  output logic        shouldBranch_o,
  output logic [15:0] branchOffset_o,
  output logic        branchDirection_o,
  output logic        flushBack_o,
  output logic        fetchHold_o,
  output logic        badOffset_o
`ifdef FETCH_SEQ_STATS_EN
  ,
  output logic [15:0] redirectCount_o,
  output logic [15:0] stallCount_o
`endif
);

  if (FLUSH_CYCLES == 0) begin : g_bad_flush_cycles
    $error("fetch_sequencer: FLUSH_CYCLES must be nonzero");
  end

  seq_state_e state_q, state_d;
  addr_t      cnt_q, cnt_d;
  addr_t      off_q, off_d;
  logic       dir_q, dir_d;
  logic       reject_s;

  logic       should_q, should_d;
  addr_t      boff_q, boff_d;
  logic       bdir_q, bdir_d;
  logic       flush_q, flush_d;
  logic       hold_q, hold_d;
  logic       bad_q, bad_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      cnt_q   <= 16'd0;
      off_q   <= 16'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    dir_d    = dir_q;
    reject_s = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (branchValid_i) begin
          if (offset_legal(branchOffset_i, addr_t'(MIN_OFFSET))) begin
            off_d   = branchOffset_i;
            dir_d   = branchDirection_i;
            cnt_d   = addr_t'(FLUSH_CYCLES);
            state_d = ST_FLUSH;
          end else begin
            // Rejected branch leaves both the mode and the latch untouched.
            reject_s = 1'b1;
          end
        end else if (stall_i) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Branch and stall inputs are wrong-path here and are ignored.
        if (cnt_q <= 16'd1) begin
          cnt_d   = 16'd0;
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_REDIRECT: begin
        if (stall_i) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    should_d = (state_d == ST_REDIRECT);
    flush_d  = (state_d == ST_FLUSH);
    hold_d   = (state_d == ST_FLUSH) || (state_d == ST_STALL);
    bad_d    = reject_s;
    if (state_d == ST_REDIRECT) begin
      boff_d = off_q;
      bdir_d = dir_q;
    end else begin
      boff_d = boff_q;
      bdir_d = bdir_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      should_q <= 1'b0;
      boff_q   <= 16'd0;
      bdir_q   <= 1'b0;
      flush_q  <= 1'b0;
      hold_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      should_q <= should_d;
      boff_q   <= boff_d;
      bdir_q   <= bdir_d;
      flush_q  <= flush_d;
      hold_q   <= hold_d;
      bad_q    <= bad_d;
    end
  end

  assign shouldBranch_o    = should_q;
  assign branchOffset_o    = boff_q;
  assign branchDirection_o = bdir_q;
  assign flushBack_o       = flush_q;
  assign fetchHold_o       = hold_q;
  assign badOffset_o       = bad_q;

`ifdef FETCH_SEQ_STATS_EN
  // Hold outside FLUSH only happens in STALL, so STALL residency is the stall count.
  fetch_seq_sat_counter u_redirect_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .inc_i   (state_q == ST_REDIRECT),
    .count_o (redirectCount_o)
  );

  fetch_seq_sat_counter u_stall_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .inc_i   (state_q == ST_STALL),
    .count_o (stallCount_o)
  );
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block that sequences the Fetch stage. It accepts branch resolutions from execute, drains the wrong-path pipeline with a timed flush, and then issues exactly one redirect pulse to Fetch. It also converts dependency-unit stalls into a fetch hold. It sits between execute/dependency logic and Fetch, and is the only source of Fetch's flush and branch inputs.

## Interface
Parameters:
- FLUSH_CYCLES, default 6: number of cycles flushBack_o is held per redirect (pipeline depth behind Fetch).
- MIN_OFFSET, default 7: smallest legal branch offset, because Fetch subtracts its own latency from the offset.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- branchValid_i  in  1  execute resolved a taken branch this cycle.
- branchOffset_i  in  16  unsigned branch distance.
- branchDirection_i  in  1  0 = backward, 1 = forward.
- stall_i  in  1  dependency unit requests fetch hold.
- shouldBranch_o  out  1  one-cycle redirect pulse to Fetch.
- branchOffset_o  out  16  latched offset, valid while shouldBranch_o = 1.
- branchDirection_o  out  1  latched direction, valid while shouldBranch_o = 1.
- flushBack_o  out  1  squash in-flight fetch output.
- fetchHold_o  out  1  freeze the Fetch PC.
- badOffset_o  out  1  one-cycle pulse when a branch is rejected.

## Operation
- FSM states: RUN, STALL, FLUSH, REDIRECT. The encoding lives in the package.
- RUN:
  - branchValid_i = 1 with offset ≥ MIN_OFFSET: latch offset and direction, load flush counter with FLUSH_CYCLES, go to FLUSH.
  - branchValid_i = 1 with offset < MIN_OFFSET: pulse badOffset_o for one cycle, stay in RUN, latch nothing.
  - Otherwise, stall_i = 1: go to STALL.
- STALL: fetchHold_o = 1.
  - stall_i = 0: return to RUN.
  - A legal branch overrides the stall and is handled exactly as in RUN (go to FLUSH). An illegal branch pulses badOffset_o and stays in STALL.
- FLUSH:
  - flushBack_o = 1 and fetchHold_o = 1.
  - Decrement the counter each cycle. When the counter reaches 1, go to REDIRECT.
  - branchValid_i is ignored, because it comes from a squashed wrong-path instruction. stall_i is ignored.
- REDIRECT:
  - shouldBranch_o = 1 for exactly one cycle, flushBack_o = 0, branchOffset_o and branchDirection_o driven from the latch.
  - Next state is STALL if stall_i = 1, otherwise RUN.
  - branchValid_i is ignored.
- Only the first branch of a burst is honored; all later ones are dropped until the FSM is back in RUN or STALL.
- The offset is passed through unmodified and 16-bit unsigned. Latency compensation is done in Fetch; the MIN_OFFSET check only guarantees that the compensated value does not underflow.
- FLUSH_CYCLES = 0 is illegal; the design uses an elaboration-time check.

## Timing
- All outputs are registered.
- Reset values: shouldBranch_o = 0, branchOffset_o = 0, branchDirection_o = 0, flushBack_o = 0, fetchHold_o = 0, badOffset_o = 0, state = RUN, counter = 0.
- Reset is asynchronous and takes effect immediately, including mid-FLUSH. A branch pending at reset is discarded, and no redirect follows reset release.
- Branch accepted at edge N:
  - flushBack_o = 1 from cycle N+1 through N+FLUSH_CYCLES.
  - shouldBranch_o = 1 at cycle N+FLUSH_CYCLES+1.
  - RUN or STALL from N+FLUSH_CYCLES+2.
- Stall: stall_i sampled high at N gives fetchHold_o = 1 at N+1. Deassertion at M gives fetchHold_o = 0 at M+1.
- badOffset_o asserts at N+1 for a rejected branch at N.
- shouldBranch_o and flushBack_o are never high in the same cycle.

## Configuration
- Macro FETCH_SEQ_STATS_EN.
- Defined: adds output ports redirectCount_o (16 bits, counts REDIRECT cycles) and stallCount_o (16 bits, counts cycles with fetchHold_o = 1 while not in FLUSH).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent, and all other behavior is identical.

## Structure
- Package fetch_seq_pkg holds:
  - the state enum typedef;
  - localparam defaults for FLUSH_CYCLES and MIN_OFFSET;
  - the 16-bit address/offset typedef shared with Fetch.
- Sub-module fetch_seq_sat_counter: a 16-bit saturating counter with increment enable, instantiated twice only under FETCH_SEQ_STATS_EN.
- The FSM and flush counter stay in the top module.

## Test plan
- Reset during FLUSH (branch offset 20 accepted, reset asserted 3 cycles later) -> all outputs 0 immediately; no shouldBranch_o after release.
- Forward branch, offset 15, in RUN at N -> flushBack_o high N+1..N+6; shouldBranch_o = 1 at N+7 with offset 15, direction 1; back to RUN at N+8.
- Backward branch, offset 4 -> badOffset_o pulse at N+1; no flush; state remains RUN.
- Second branch (offset 30) during FLUSH of the first (offset 10) -> only offset 10 is redirected; exactly one shouldBranch_o pulse.
- stall_i high for 5 cycles, with a branch (offset 12) arriving on the 3rd -> fetchHold_o stays high; flush/redirect proceed; after REDIRECT with stall_i low -> RUN, fetchHold_o = 0.
- With FETCH_SEQ_STATS_EN defined: 3 redirects plus 4 stall cycles -> redirectCount_o = 3, stallCount_o = 4.
